// File: rtl/unified_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one single-ported I+D memory between the CPU fetch and
//               data ports; one read outstanding, read data routed by owner.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic [3:0]            d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  m_req,
    output logic [3:0]            m_wen,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ready,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic [CNT_WIDTH-1:0]  gnt_i_cnt,
    output logic [CNT_WIDTH-1:0]  gnt_d_cnt,
    output logic [CNT_WIDTH-1:0]  conflict_cnt,
    output logic                  err_spurious
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           starve_q, starve_d;
    logic [CNT_WIDTH-1:0] gnt_i_cnt_q, gnt_i_cnt_d;
    logic [CNT_WIDTH-1:0] gnt_d_cnt_q, gnt_d_cnt_d;
    logic [CNT_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;
    logic                 err_q, err_d;

    logic window;
    logic pick_d;

    // A returning read frees the memory port in the same cycle, so a new
    // request may issue alongside the rvalid.
    always_comb begin
        window   = (state_q == IDLE) || m_rvalid;
        pick_d   = d_req && !(i_req && (starve_q == STARVE_MAX));
        m_req    = rst_n && window && (i_req || d_req);
        d_gnt    = m_req && m_ready && pick_d;
        i_gnt    = m_req && m_ready && !pick_d;
        m_addr   = pick_d ? d_addr : i_addr;
        m_wen    = pick_d ? d_wen : 4'h0;
        m_wdata  = d_wdata;
        i_rvalid = rst_n && m_rvalid && (state_q == WAIT_I);
        d_rvalid = rst_n && m_rvalid && (state_q == WAIT_D);
        i_rdata  = m_rdata;
        d_rdata  = m_rdata;
    end

    always_comb begin
        state_d = state_q;
        if (i_gnt) begin
            state_d = WAIT_I;
        end else if (d_gnt) begin
            state_d = (d_wen == 4'h0) ? WAIT_D : IDLE;
        end else if (m_rvalid) begin
            state_d = IDLE;
        end

        starve_d = starve_q;
        if (i_gnt || !i_req) begin
            starve_d = 4'd0;
        end else if (d_gnt && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end

        gnt_i_cnt_d    = gnt_i_cnt_q + {{(CNT_WIDTH-1){1'b0}}, i_gnt};
        gnt_d_cnt_d    = gnt_d_cnt_q + {{(CNT_WIDTH-1){1'b0}}, d_gnt};
        conflict_cnt_d = conflict_cnt_q
                       + {{(CNT_WIDTH-1){1'b0}}, (i_req && d_req && (i_gnt || d_gnt))};
        err_d          = err_q || (m_rvalid && (state_q == IDLE));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            starve_q       <= 4'd0;
            gnt_i_cnt_q    <= '0;
            gnt_d_cnt_q    <= '0;
            conflict_cnt_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            starve_q       <= starve_d;
            gnt_i_cnt_q    <= gnt_i_cnt_d;
            gnt_d_cnt_q    <= gnt_d_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
            err_q          <= err_d;
        end
    end

    assign gnt_i_cnt    = gnt_i_cnt_q;
    assign gnt_d_cnt    = gnt_d_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
    assign err_spurious = err_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Random + directed bench for unified_mem_arbiter against a
//               transaction-level model and a latency-programmable memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic [3:0]    d_wen;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_req;
    logic [3:0]    m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ready, m_rvalid;
    logic [DW-1:0] m_rdata;
    logic [CW-1:0] gnt_i_cnt, gnt_d_cnt, conflict_cnt;
    logic          err_spurious;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .gnt_i_cnt(gnt_i_cnt), .gnt_d_cnt(gnt_d_cnt), .conflict_cnt(conflict_cnt),
        .err_spurious(err_spurious)
    );

    // Memory device
    logic [31:0] mem [0:255];
    int          pend_cnt;
    logic [31:0] pend_data;
    int          lat_fix;
    bit          force_rv;

    // Reference model: owner of the outstanding read (0 none, 1 I, 2 D)
    int          mdl_owner;
    int          mdl_starve;
    int unsigned mdl_gi, mdl_gd, mdl_conf;
    bit          mdl_err;
    bit          mdl_last_ig, mdl_last_dg;
    logic [1:0]  obs_gnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic mem_tick();
        m_rvalid = 1'b0;
        m_rdata  = $urandom;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                m_rvalid = 1'b1;
                m_rdata  = pend_data;
            end
        end
        if (force_rv) m_rvalid = 1'b1;
    endtask

    function automatic int pick_lat();
        return (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
    endfunction

    // One clock cycle: inputs already driven at posedge+1.
    task automatic step();
        bit win, pick_d, e_mreq, e_ig, e_dg, e_irv, e_drv;
        mem_tick();
        #3;
        win    = (mdl_owner == 0) || m_rvalid;
        pick_d = d_req && !(i_req && (mdl_starve == SL));
        e_mreq = win && (i_req || d_req);
        e_ig   = e_mreq && m_ready && !pick_d;
        e_dg   = e_mreq && m_ready && pick_d;
        e_irv  = m_rvalid && (mdl_owner == 1);
        e_drv  = m_rvalid && (mdl_owner == 2);
        obs_gnt = {i_gnt, d_gnt};
        check_eq("ctl{mreq,ig,dg,irv,drv}", {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid},
                 {e_mreq, e_ig, e_dg, e_irv, e_drv});
        if (e_mreq) check_eq("m_addr", m_addr, pick_d ? d_addr : i_addr);
        if (e_mreq) check_eq("m_wen", m_wen, pick_d ? d_wen : 4'h0);
        if (e_dg && d_wen != 4'h0) check_eq("m_wdata", m_wdata, d_wdata);
        if (e_irv) check_eq("i_rdata", i_rdata, m_rdata);
        if (e_drv) check_eq("d_rdata", d_rdata, m_rdata);
        check_eq("gnt_i_cnt", gnt_i_cnt, mdl_gi);
        check_eq("gnt_d_cnt", gnt_d_cnt, mdl_gd);
        check_eq("conflict_cnt", conflict_cnt, mdl_conf);
        check_eq("err_spurious", err_spurious, mdl_err);

        if (m_rvalid && mdl_owner == 0) mdl_err = 1'b1;
        if ((e_ig || e_dg) && i_req && d_req) mdl_conf++;
        if (e_ig) mdl_gi++;
        if (e_dg) mdl_gd++;
        if (e_ig || !i_req) mdl_starve = 0;
        else if (e_dg && mdl_starve < SL) mdl_starve++;

        if (e_ig) begin
            pend_cnt  = pick_lat();
            pend_data = mem[i_addr[9:2]];
            mdl_owner = 1;
        end else if (e_dg) begin
            if (d_wen == 4'h0) begin
                pend_cnt  = pick_lat();
                pend_data = mem[d_addr[9:2]];
                mdl_owner = 2;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (d_wen[k]) mem[d_addr[9:2]][8*k +: 8] = d_wdata[8*k +: 8];
                mdl_owner = 0;
            end
        end else if (m_rvalid) begin
            mdl_owner = 0;
        end
        mdl_last_ig = e_ig;
        mdl_last_dg = e_dg;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int c = 0; c < n; c++) begin
            mem_tick();
            #3;
            check_eq("reset_outs", {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid}, 5'b0);
            @(posedge clk);
            #1;
        end
        rst_n       = 1'b1;
        mdl_owner   = 0;
        mdl_starve  = 0;
        mdl_gi      = 0;
        mdl_gd      = 0;
        mdl_conf    = 0;
        mdl_err     = 1'b0;
        mdl_last_ig = 1'b0;
        mdl_last_dg = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        i_req = 1'b0;
        d_req = 1'b0;
        for (int c = 0; c < n; c++) step();
    endtask

    logic [1:0] exp_order [10];

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = $urandom;
        pend_cnt = 0; pend_data = '0; lat_fix = 0; force_rv = 1'b0;
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_wen = 4'h0;
        d_addr = 32'h20; d_wdata = '0; m_ready = 1'b1; m_rvalid = 1'b0; m_rdata = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3);
        check_eq("rst_cnt_i", gnt_i_cnt, 0);
        check_eq("rst_cnt_d", gnt_d_cnt, 0);
        check_eq("rst_conflict", conflict_cnt, 0);
        check_eq("rst_err", err_spurious, 0);

        // I-only fetches, latency 1: back-to-back grants
        lat_fix = 1; d_req = 1'b0; i_req = 1'b1; i_addr = 32'h10;
        step();
        check_eq("ifetch_gnt0", obs_gnt, 2'b10);
        step();
        check_eq("ifetch_gnt1", obs_gnt, 2'b10);
        check_eq("ifetch_cnt", gnt_i_cnt, 2);
        idle_steps(3);

        // Starvation: D wins four times, then I
        do_reset(1);
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        i_req = 1'b1; d_req = 1'b1; d_wen = 4'h0; m_ready = 1'b1; lat_fix = 1;
        for (int g = 0; g < 10; g++) begin
            step();
            check_eq($sformatf("order[%0d]", g), obs_gnt, exp_order[g]);
        end
        check_eq("starve_conflict", conflict_cnt, 10);
        check_eq("starve_cnt_d", gnt_d_cnt, 8);
        check_eq("starve_cnt_i", gnt_i_cnt, 2);
        idle_steps(3);

        // D write with I pending: write completes on acceptance, I follows
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_wen = 4'hF;
        d_addr = 32'h300; d_wdata = 32'h1;
        step();
        check_eq("wr_gnt", obs_gnt, 2'b01);
        d_req = 1'b0;
        step();
        check_eq("wr_then_i_gnt", obs_gnt, 2'b10);
        check_eq("wr_mem", mem[8'hC0], 32'h1);
        idle_steps(3);

        // Memory back-pressure
        d_req = 1'b1; d_wen = 4'h3; d_addr = 32'h44; d_wdata = $urandom; m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("stall_nogrant", obs_gnt, 2'b00);
        end
        m_ready = 1'b1;
        step();
        check_eq("stall_release", obs_gnt, 2'b01);
        idle_steps(2);

        // Randomized traffic with random latency and ready
        lat_fix = 0;
        i_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!(i_req && !mdl_last_ig)) begin
                i_req  = ($urandom_range(0, 99) < 70);
                i_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (!(d_req && !mdl_last_dg)) begin
                d_req   = ($urandom_range(0, 99) < 60);
                d_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                d_addr  = 32'($urandom_range(0, 255)) << 2;
                d_wdata = $urandom;
            end
            m_ready = ($urandom_range(0, 99) < 75);
            step();
        end
        m_ready = 1'b1;
        idle_steps(5);

        // Reset while a D read is outstanding; the late rvalid is spurious
        lat_fix = 4; d_req = 1'b1; d_wen = 4'h0; d_addr = 32'h80; i_req = 1'b0;
        step();
        check_eq("midrd_gnt", obs_gnt, 2'b01);
        d_req = 1'b0;
        step();
        i_req = 1'b1; d_req = 1'b1;
        do_reset(1);
        check_eq("midrd_cnt_d", gnt_d_cnt, 0);
        idle_steps(2);
        check_eq("midrd_err", err_spurious, 1);
        check_eq("midrd_conflict", conflict_cnt, 0);

        // Spurious rvalid in IDLE stays flagged
        do_reset(1);
        force_rv = 1'b1;
        idle_steps(1);
        force_rv = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            check_eq("err_sticky", err_spurious, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
